sar_logic: RTL

Successive-approximation controller for the ideal SAR ADC model. It sits directly downstream of the sample-and-hold stage. It drives the hold control into that stage and reads back the held voltage. It then runs a BITS-step binary search against an ideal internal DAC/comparator and presents the converted code with a one-cycle valid pulse. Conversion steps advance on rising edges of the slow `sys_clk`, which is observed in the fast `clk` domain.

---
 rtl/sar_adc_pkg.sv | 18 +
 rtl/sys_clk_edge_detect.sv | 19 +
 rtl/sar_logic.sv | 115 +++++++++++
 3 files changed

// File: rtl/sar_adc_pkg.sv
// sar_adc_pkg: shared state encoding, default resolution and ideal compare rule for the SAR ADC model
package sar_adc_pkg;

    localparam int SAR_BITS = 10;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        CONVERT,
        DONE
    } sar_state_e;

    // Ideal comparator: a trial bit is kept when the held voltage reaches the trial code
    function automatic logic sar_keep_bit(input logic [31:0] held, input logic [31:0] trial);
        return held >= trial;
    endfunction

endpackage

// File: rtl/sys_clk_edge_detect.sv
// sys_clk_edge_detect: rising-edge detector for the slow sys_clk observed in the clk domain
module sys_clk_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sys_clk,
    output logic sys_edge_o
);

    logic prev_sys_clk_q;

    // Remember last sampled sys_clk level to spot 0->1 transitions
    always_ff @(posedge clk) begin
        if (reset) prev_sys_clk_q <= 1'b0;
        else       prev_sys_clk_q <= sys_clk;
    end

    assign sys_edge_o = sys_clk & ~prev_sys_clk_q;

endmodule

// File: rtl/sar_logic.sv
// sar_logic: successive-approximation controller driving S&H hold and an ideal DAC/comparator
module sar_logic
    import sar_adc_pkg::*;
#(
    parameter int BITS          = SAR_BITS,
    parameter int SAMPLE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sys_clk,
    input  logic            start,
    input  logic [BITS-1:0] held_voltage_real,
    output logic            hold_control_digital,
    output logic [BITS-1:0] dac_code,
    output logic            busy,
    output logic            result_valid,
    output logic [BITS-1:0] result_code
);

    localparam int         IW       = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [3:0] CNT_LAST = 4'(SAMPLE_CYCLES - 1);

    sar_state_e      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [BITS-1:0] approx_q, approx_d;
    logic [BITS-1:0] result_q, result_d;
    logic [BITS-1:0] dac_q, dac_d;
    logic [BITS-1:0] trial;
    logic            hold_q, hold_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic            sys_edge;

    sys_clk_edge_detect u_edge (
        .clk        (clk),
        .reset      (reset),
        .sys_clk    (sys_clk),
        .sys_edge_o (sys_edge)
    );

    // Trial code currently on the DAC; identical to dac_q while converting
    assign trial = approx_q | (BITS'(1) << idx_q);

    // Next-state logic; outputs are derived from the next state so every output is registered
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        approx_d = approx_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SAMPLE;
                    cnt_d   = '0;
                end
            end
            SAMPLE: begin
                if (sys_edge) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_d  = CONVERT;
                        idx_d    = IW'(BITS - 1);
                        approx_d = '0;
                    end
                end
            end
            CONVERT: begin
                if (sys_edge) begin
                    approx_d = sar_keep_bit(32'(held_voltage_real), 32'(trial)) ? trial : approx_q;
                    if (idx_q == '0) state_d = DONE;
                    else             idx_d   = idx_q - IW'(1);
                end
            end
            DONE: state_d = IDLE;
        endcase
        hold_d   = state_d == CONVERT;
        busy_d   = (state_d == SAMPLE) || (state_d == CONVERT);
        dac_d    = (state_d == CONVERT) ? (approx_d | (BITS'(1) << idx_d)) : '0;
        valid_d  = state_d == DONE;
        result_d = valid_d ? approx_d : result_q;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= IW'(BITS - 1);
            approx_q <= '0;
            hold_q   <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
            dac_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            approx_q <= approx_d;
            hold_q   <= hold_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            dac_q    <= dac_d;
        end
    end

    assign hold_control_digital = hold_q;
    assign busy                 = busy_q;
    assign result_valid         = valid_q;
    assign result_code          = result_q;
    assign dac_code             = dac_q;

endmodule
